// File: rtl/pcap_dma_pkg.sv
// Shared types and defaults for the position-capture DMA packer.
package pcap_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BURST,
        END
    } dma_state_e;

    localparam int BURST_LEN_DEF    = 16;
    localparam int AFULL_MARGIN_DEF = 4;
    localparam int DMA_LEN_W        = 8;

endpackage

// File: rtl/pcap_dma_fifo.sv
// Word FIFO for the DMA packer: dual-port RAM with registered read data and
// extra-MSB pointers so full/empty/count fall out of plain pointer arithmetic.
module pcap_dma_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage and read register carry data only, so they are left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        if (rd_en) rd_data <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/pcap_dma_packer.sv
// Buffers pcap words and hands them to the DMA engine as fixed bursts plus a short final burst.
// Optional idle-timeout partial flush is enabled by defining PCAP_DMA_TIMEOUT_EN.
module pcap_dma_packer
    import pcap_dma_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int BURST_LEN    = BURST_LEN_DEF,
    parameter int AFULL_MARGIN = AFULL_MARGIN_DEF,
    parameter int TIMEOUT      = 1250000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [31:0]           pcap_dat_i,
    input  logic                  pcap_dat_valid_i,
    input  logic                  pcap_done_i,
    input  logic                  pcap_actv_i,
    output logic                  dma_req_o,
    output logic [DMA_LEN_W-1:0]  dma_len_o,
    input  logic                  dma_ack_i,
    output logic [31:0]           dma_dat_o,
    output logic                  dma_dat_valid_o,
    output logic                  dma_last_o,
    output logic                  dma_end_o,
    output logic                  dma_full_o,
    output logic                  overflow_o,
    output logic [DEPTH_LOG2:0]   fill_level_o
);

    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0]     BURST_CNT   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]     AFULL_CNT   = CNT_W'(DEPTH - AFULL_MARGIN);
    localparam logic [DMA_LEN_W-1:0] BURST_LEN_W = DMA_LEN_W'(BURST_LEN);

    dma_state_e           state_q, state_d;
    logic [DMA_LEN_W-1:0] len_q, len_d;
    logic                 final_q, final_d;
    logic [DMA_LEN_W-1:0] rd_cnt_q;
    logic                 done_pend_q;
    logic                 ovf_q, ovf_d;
    logic                 dma_full_q;
    logic                 actv_q;
    logic                 actv_rise;

    logic                 wr_en, drop, rd_en, last_rd;
    logic [31:0]          fifo_rd_data;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count, cnt_next;
    logic                 timeout_hit;

    logic                 vld_p1, last_p1;

    assign wr_en     = pcap_dat_valid_i && !fifo_full;
    assign drop      = pcap_dat_valid_i && fifo_full;
    assign rd_en     = (state_q == BURST) && !fifo_empty;
    assign last_rd   = rd_en && (rd_cnt_q == len_q - 1'b1);
    assign actv_rise = pcap_actv_i && !actv_q;

    pcap_dma_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_en   (wr_en),
        .wr_data (pcap_dat_i),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef PCAP_DMA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    logic [TO_W-1:0] idle_cnt_q;

    // Saturates at TIMEOUT so a long quiet period cannot wrap and re-fire.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                  idle_cnt_q <= '0;
        else if (wr_en)               idle_cnt_q <= '0;
        else if (idle_cnt_q != TO_VAL) idle_cnt_q <= idle_cnt_q + 1'b1;
    end

    assign timeout_hit = (idle_cnt_q == TO_VAL);
`else
    assign timeout_hit = 1'b0;
`endif

    // Look-ahead count so dma_full_o lines up with fill_level_o.
    assign cnt_next = fifo_count + CNT_W'(wr_en) - CNT_W'(rd_en);
    assign ovf_d    = (ovf_q && !actv_rise) || drop;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        final_d = final_q;
        case (state_q)
            IDLE: begin
                if (fifo_count >= BURST_CNT) begin
                    state_d = REQ;
                    len_d   = BURST_LEN_W;
                    final_d = 1'b0;
                end else if ((fifo_count != '0) && (done_pend_q || timeout_hit)) begin
                    state_d = REQ;
                    len_d   = DMA_LEN_W'(fifo_count);
                    final_d = done_pend_q;
                end else if (done_pend_q) begin
                    state_d = END;
                end
            end
            REQ:     if (dma_ack_i) state_d = BURST;
            BURST:   if (last_rd) state_d = IDLE;
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            final_q     <= 1'b0;
            rd_cnt_q    <= '0;
            done_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            dma_full_q  <= 1'b0;
            actv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            final_q    <= final_d;
            actv_q     <= pcap_actv_i;
            ovf_q      <= ovf_d;
            dma_full_q <= ovf_d || (cnt_next >= AFULL_CNT);
            if (rd_en) rd_cnt_q <= last_rd ? '0 : rd_cnt_q + 1'b1;
            if (actv_rise)           done_pend_q <= 1'b0;
            else if (pcap_done_i)    done_pend_q <= 1'b1;
            else if (state_q == END) done_pend_q <= 1'b0;
        end
    end

    // ---- p1: RAM read data is valid one cycle after the read ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= rd_en;
            last_p1 <= last_rd && final_q;
        end
    end

    assign dma_req_o       = (state_q == REQ);
    assign dma_len_o       = len_q;
    assign dma_end_o       = (state_q == END);
    assign dma_dat_valid_o = vld_p1;
    assign dma_dat_o       = vld_p1 ? fifo_rd_data : '0;
    assign dma_last_o      = last_p1;
    assign dma_full_o      = dma_full_q;
    assign overflow_o      = ovf_q;
    assign fill_level_o    = fifo_count;

endmodule

// File: tb/tb_pcap_dma_packer.sv
// Scoreboard bench for pcap_dma_packer: burst splitting, data order, last/end flags, almost-full and reset.
module tb_pcap_dma_packer;

    localparam int DL2   = 5;
    localparam int BL    = 16;
    localparam int AFM   = 4;
    localparam int TO    = 100;
    localparam int DEPTH = 1 << DL2;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [31:0]    pcap_dat_i = '0;
    logic           pcap_dat_valid_i = 1'b0;
    logic           pcap_done_i = 1'b0;
    logic           pcap_actv_i = 1'b1;
    logic           dma_req_o;
    logic [7:0]     dma_len_o;
    logic           dma_ack_i = 1'b0;
    logic [31:0]    dma_dat_o;
    logic           dma_dat_valid_o;
    logic           dma_last_o;
    logic           dma_end_o;
    logic           dma_full_o;
    logic           overflow_o;
    logic [DL2:0]   fill_level_o;

    pcap_dma_packer #(
        .DEPTH_LOG2   (DL2),
        .BURST_LEN    (BL),
        .AFULL_MARGIN (AFM),
        .TIMEOUT      (TO)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .pcap_dat_i       (pcap_dat_i),
        .pcap_dat_valid_i (pcap_dat_valid_i),
        .pcap_done_i      (pcap_done_i),
        .pcap_actv_i      (pcap_actv_i),
        .dma_req_o        (dma_req_o),
        .dma_len_o        (dma_len_o),
        .dma_ack_i        (dma_ack_i),
        .dma_dat_o        (dma_dat_o),
        .dma_dat_valid_o  (dma_dat_valid_o),
        .dma_last_o       (dma_last_o),
        .dma_end_o        (dma_end_o),
        .dma_full_o       (dma_full_o),
        .overflow_o       (overflow_o),
        .fill_level_o     (fill_level_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;

    word_t exp_w[$];
    int    exp_len[$];
    int    ack_q[$];
    int    blen_q[$];
    int    exp_end   = 0;
    bit    sb_en     = 1'b0;
    bit    auto_ack  = 1'b0;
    bit    had_words = 1'b0;
    int    ack_dly   = 3;
    int    n_chk     = 0;
    int    n_err     = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void note_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: event not expected or never happened (cycle %0d)", name, cyc);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // DMA engine stand-in: acks each request ack_dly cycles after it appears.
    initial begin
        int age;
        age = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (dma_ack_i) begin
                dma_ack_i = 1'b0;
            end else if (auto_ack && dma_req_o && !reset_i) begin
                age++;
                if (age > ack_dly) begin
                    dma_ack_i = 1'b1;
                    ack_q.push_back(cyc);
                    age = 0;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents something.
    initial begin
        int    burst_rem, req_len, last_cyc;
        bit    req_seen, end_prev;
        word_t w;
        burst_rem = 0; req_len = 0; last_cyc = 0; req_seen = 0; end_prev = 0;
        forever begin
            @(negedge clk_i);
            if (!sb_en || reset_i) begin
                burst_rem = 0;
                req_seen  = 0;
                end_prev  = 0;
            end else begin
                if (dma_req_o) begin
                    if (!req_seen) begin
                        req_seen = 1;
                        req_len  = dma_len_o;
                        blen_q.push_back(dma_len_o);
                        if (exp_len.size() == 0) note_fail("req_unexpected");
                        else chk("req_len", dma_len_o, exp_len.pop_front());
                    end else begin
                        chk("len_stable", dma_len_o, req_len);
                    end
                end else begin
                    req_seen = 0;
                end
                if (dma_dat_valid_o) begin
                    if (burst_rem == 0) begin
                        if (blen_q.size() == 0) begin
                            note_fail("burst_unrequested");
                            burst_rem = 1;
                        end else begin
                            burst_rem = blen_q.pop_front();
                        end
                        if (ack_q.size() == 0) note_fail("ack_missing");
                        else chk("ack_to_data", cyc - ack_q.pop_front(), 2);
                    end
                    if (exp_w.size() == 0) begin
                        note_fail("word_unexpected");
                    end else begin
                        w = exp_w.pop_front();
                        chk("data", dma_dat_o, w.d);
                        chk("last", dma_last_o, w.l);
                    end
                    burst_rem--;
                    last_cyc = cyc;
                end else if (burst_rem != 0) begin
                    note_fail("burst_contiguous");
                    burst_rem = 0;
                end
                if (dma_end_o) begin
                    chk("end_single", end_prev, 0);
                    if (exp_end == 0) begin
                        note_fail("end_unexpected");
                    end else begin
                        exp_end--;
                        chk("end_drained", exp_w.size(), 0);
                        if (had_words) chk("end_after_last", cyc - last_cyc, 1);
                    end
                end
                end_prev = dma_end_o;
            end
        end
    end

    // One capture run: n words, then done. Expected bursts follow from n alone.
    task automatic run(input int n, input int gapmax, input bit seq, input int base);
        word_t w;
        int    t;
        for (int b = 0; b < n / BL; b++) exp_len.push_back(BL);
        if (n % BL != 0) exp_len.push_back(n % BL);
        exp_end++;
        had_words = (n > 0);
        for (int i = 0; i < n; i++) begin
            w.d = seq ? 32'(base + i) : $urandom;
            w.l = (n % BL != 0) && (i == n - 1);
            exp_w.push_back(w);
            pcap_dat_i       = w.d;
            pcap_dat_valid_i = 1'b1;
            tick();
            pcap_dat_valid_i = 1'b0;
            repeat ($urandom_range(0, gapmax)) tick();
        end
        pcap_done_i = 1'b1;
        tick();
        pcap_done_i = 1'b0;
        t = 0;
        while ((exp_end != 0 || exp_w.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        chk("run_complete", exp_end + exp_w.size(), 0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  t;
        bit  seen;
        int  t0;
        int  fill_e;
        reset_i = 1'b1;
        repeat (3) tick();
        chk("rst_req", dma_req_o, 0);
        chk("rst_valid", dma_dat_valid_o, 0);
        chk("rst_end", dma_end_o, 0);
        chk("rst_full", dma_full_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_fill", fill_level_o, 0);
        reset_i = 1'b0;
        tick();

        sb_en = 1'b1; auto_ack = 1'b1; ack_dly = 3;
        run(32, 0, 1'b1, 1);
        run(20, 0, 1'b1, 101);

        // done with an empty FIFO: end pulse two cycles after done
        exp_end++;
        had_words   = 1'b0;
        pcap_done_i = 1'b1;
        tick();
        pcap_done_i = 1'b0;
        chk("empty_end_c1", dma_end_o, 0);
        tick();
        chk("empty_end_c2", dma_end_o, 1);
        tick();
        chk("empty_end_c3", dma_end_o, 0);
        chk("empty_no_req", dma_req_o, 0);
        repeat (2) tick();

        for (int r = 0; r < 8; r++) begin
            ack_dly = $urandom_range(1, 5);
            run($urandom_range(0, 48), 3, 1'b0, 0);
        end

        // never ack: fill past the almost-full point and into overflow
        sb_en = 1'b0; auto_ack = 1'b0;
        for (int k = 1; k <= DEPTH + 4; k++) begin
            pcap_dat_i       = 32'(k);
            pcap_dat_valid_i = 1'b1;
            tick();
            fill_e = (k > DEPTH) ? DEPTH : k;
            chk("ovf_fill", fill_level_o, fill_e);
            chk("ovf_full", dma_full_o, (fill_e >= DEPTH - AFM) || (k > DEPTH));
            chk("ovf_flag", overflow_o, k > DEPTH);
        end
        pcap_dat_valid_i = 1'b0;
        pcap_actv_i = 1'b0;
        tick();
        pcap_actv_i = 1'b1;
        tick();
        chk("rearm_ovf_clear", overflow_o, 0);
        chk("rearm_still_full", dma_full_o, 1);
        do_reset();
        chk("post_ovf_fill", fill_level_o, 0);

        // reset asserted while word 5 of a burst is on the bus
        auto_ack = 1'b1; ack_dly = 3;
        for (int i = 0; i < BL; i++) begin
            pcap_dat_i       = 32'(i + 1);
            pcap_dat_valid_i = 1'b1;
            tick();
        end
        pcap_dat_valid_i = 1'b0;
        t = 0; seen = 1'b0;
        while (!seen && t < 500) begin
            @(negedge clk_i);
            t++;
            if (dma_dat_valid_o && dma_dat_o == 32'd5) seen = 1'b1;
        end
        if (!seen) note_fail("midburst_word5");
        reset_i = 1'b1;
        #1;
        chk("mid_rst_req", dma_req_o, 0);
        chk("mid_rst_valid", dma_dat_valid_o, 0);
        chk("mid_rst_dat", dma_dat_o, 0);
        chk("mid_rst_last", dma_last_o, 0);
        chk("mid_rst_len", dma_len_o, 0);
        chk("mid_rst_fill", fill_level_o, 0);
        auto_ack = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        ack_q.delete(); blen_q.delete(); exp_w.delete(); exp_len.delete();
        exp_end = 0;
        sb_en = 1'b1; auto_ack = 1'b1;
        run(20, 0, 1'b1, 1);

`ifdef PCAP_DMA_TIMEOUT_EN
        begin
            word_t w;
            had_words = 1'b0;
            exp_len.push_back(3);
            for (int i = 0; i < 3; i++) begin
                w.d = 32'(500 + i);
                w.l = 1'b0;
                exp_w.push_back(w);
                pcap_dat_i       = w.d;
                pcap_dat_valid_i = 1'b1;
                tick();
            end
            pcap_dat_valid_i = 1'b0;
            t0 = cyc;
            t  = 0;
            while (!dma_req_o && t < 400) begin
                tick();
                t++;
            end
            chk("timeout_delay_ok", (cyc - t0 >= TO) && (cyc - t0 <= TO + 2), 1);
            t = 0;
            while (exp_w.size() != 0 && t < 200) begin
                tick();
                t++;
            end
            chk("timeout_drained", exp_w.size(), 0);
            run(0, 0, 1'b0, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
